// File: rtl/inst_sequencer_if.sv
// Signals between the SPI/control side (master) and the acquisition sequencer
// (slave): instruction pulses, trigger configuration, discriminator hits and
// the per-channel readout handshake.
interface inst_sequencer_if;
    logic       inst_rst;
    logic       inst_readout;
    logic       inst_start;
    logic [7:0] trigger_channel_mask;
    logic [7:0] trig_delay;
    logic [7:0] trig_in;
    logic       readout_ack;
    logic       sample_en;
    logic       trigger_out;
    logic [7:0] trig_latched;
    logic       readout_req;
    logic [2:0] readout_ch;
    logic       core_rst;
    logic       busy;
    logic [7:0] trig_count;

    modport master (
        output inst_rst, inst_readout, inst_start, trigger_channel_mask,
               trig_delay, trig_in, readout_ack,
        input  sample_en, trigger_out, trig_latched, readout_req, readout_ch,
               core_rst, busy, trig_count
    );

    modport slave (
        input  inst_rst, inst_readout, inst_start, trigger_channel_mask,
               trig_delay, trig_in, readout_ack,
        output sample_en, trigger_out, trig_latched, readout_req, readout_ch,
               core_rst, busy, trig_count
    );
endinterface

// File: rtl/inst_sequencer.sv
// Acquisition sequencer: arms the sampling core on a start instruction,
// captures the masked hit pattern, waits the programmed post-trigger delay,
// then serves the latched channels one by one in ascending order.
module inst_sequencer (
    input  logic           iclk,
    input  logic           rst,
    inst_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, HOLD, READOUT, CLEAR} state_t;

    // Core reset is held while the clear counter runs 3,2,1,0: four cycles.
    localparam logic [1:0] CLEAR_START = 2'd3;

    state_t     state_q, state_d;
    logic       sample_en_q, sample_en_d;
    logic       trigger_out_q, trigger_out_d;
    logic [7:0] trig_latched_q, trig_latched_d;
    logic       readout_req_q, readout_req_d;
    logic [2:0] readout_ch_q, readout_ch_d;
    logic       core_rst_q, core_rst_d;
    logic       busy_q, busy_d;
    logic [7:0] trig_count_q, trig_count_d;
    logic [7:0] delay_cnt_q, delay_cnt_d;
    logic [1:0] clear_cnt_q, clear_cnt_d;

    logic       do_rst, do_readout, do_start;
    logic [7:0] hit;
    logic [7:0] remaining;

    // Index of the lowest set bit; callers only use it on a non-zero vector.
    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Instruction priority: reset beats readout beats start; losers are dropped.
    always_comb begin
        do_rst     = bus.inst_rst;
        do_readout = bus.inst_readout & ~bus.inst_rst;
        do_start   = bus.inst_start & ~bus.inst_readout & ~bus.inst_rst;
        hit        = bus.trig_in & bus.trigger_channel_mask;
        // Channels strictly above the one being served are still pending.
        remaining  = trig_latched_q & 8'(9'h1FE << readout_ch_q);
    end

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        // NOTE: every *_d gets a default before any branch, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d        = state_q;
        sample_en_d    = sample_en_q;
        trigger_out_d  = 1'b0;
        trig_latched_d = trig_latched_q;
        readout_req_d  = readout_req_q;
        readout_ch_d   = readout_ch_q;
        core_rst_d     = core_rst_q;
        busy_d         = busy_q;
        trig_count_d   = trig_count_q;
        delay_cnt_d    = delay_cnt_q;
        clear_cnt_d    = clear_cnt_q;

        if (do_rst) begin
            state_d        = CLEAR;
            sample_en_d    = 1'b0;
            trig_latched_d = 8'd0;
            readout_req_d  = 1'b0;
            readout_ch_d   = 3'd0;
            core_rst_d     = 1'b1;
            busy_d         = 1'b1;
            trig_count_d   = 8'd0;
            delay_cnt_d    = 8'd0;
            clear_cnt_d    = CLEAR_START;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (do_start) begin
                        state_d     = ARMED;
                        sample_en_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                ARMED: begin
                    if (do_readout) begin
                        // Forced readout serves every enabled channel.
                        sample_en_d = 1'b0;
                        if (bus.trigger_channel_mask != 8'd0) begin
                            state_d        = READOUT;
                            trig_latched_d = bus.trigger_channel_mask;
                            readout_req_d  = 1'b1;
                            readout_ch_d   = lowest_bit(bus.trigger_channel_mask);
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (hit != 8'd0) begin
                        state_d        = DELAY;
                        trig_latched_d = hit;
                        trig_count_d   = trig_count_q + 8'd1;
                        delay_cnt_d    = bus.trig_delay;
                    end
                end
                DELAY: begin
                    if (delay_cnt_q == 8'd0) begin
                        state_d       = HOLD;
                        sample_en_d   = 1'b0;
                        trigger_out_d = 1'b1;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (do_readout) begin
                        state_d       = READOUT;
                        readout_req_d = 1'b1;
                        readout_ch_d  = lowest_bit(trig_latched_q);
                    end
                end
                READOUT: begin
                    if (readout_req_q && bus.readout_ack) begin
                        if (remaining != 8'd0) begin
                            readout_ch_d = lowest_bit(remaining);
                        end else begin
                            state_d        = IDLE;
                            readout_req_d  = 1'b0;
                            trig_latched_d = 8'd0;
                            busy_d         = 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    if (clear_cnt_q == 2'd0) begin
                        state_d    = IDLE;
                        core_rst_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        clear_cnt_d = clear_cnt_q - 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iclk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values of the others, independent of statement order.
        if (rst) begin
            state_q        <= IDLE;
            sample_en_q    <= 1'b0;
            trigger_out_q  <= 1'b0;
            trig_latched_q <= 8'd0;
            readout_req_q  <= 1'b0;
            readout_ch_q   <= 3'd0;
            core_rst_q     <= 1'b0;
            busy_q         <= 1'b0;
            trig_count_q   <= 8'd0;
            delay_cnt_q    <= 8'd0;
            clear_cnt_q    <= 2'd0;
        end else begin
            state_q        <= state_d;
            sample_en_q    <= sample_en_d;
            trigger_out_q  <= trigger_out_d;
            trig_latched_q <= trig_latched_d;
            readout_req_q  <= readout_req_d;
            readout_ch_q   <= readout_ch_d;
            core_rst_q     <= core_rst_d;
            busy_q         <= busy_d;
            trig_count_q   <= trig_count_d;
            delay_cnt_q    <= delay_cnt_d;
            clear_cnt_q    <= clear_cnt_d;
        end
    end

    assign bus.sample_en    = sample_en_q;
    assign bus.trigger_out  = trigger_out_q;
    assign bus.trig_latched = trig_latched_q;
    assign bus.readout_req  = readout_req_q;
    assign bus.readout_ch   = readout_ch_q;
    assign bus.core_rst     = core_rst_q;
    assign bus.busy         = busy_q;
    assign bus.trig_count   = trig_count_q;
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: iclk  in  1  internal clock, all logic on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled only on rising iclk.
REQ-003 inst_rst  in  1  single-iclk pulse, reset instruction from SPI block.
REQ-004 inst_readout  in  1  single-iclk pulse, readout instruction.
REQ-005 inst_start  in  1  single-iclk pulse, start instruction.
REQ-006 trigger_channel_mask  in  8  per-channel trigger enable, static while busy.
REQ-007 trig_delay  in  8  post-trigger delay in iclk cycles, static while busy.
REQ-008 trig_in  in  8  discriminator hits, already iclk-synchronous.
REQ-009 readout_ack  in  1  downstream accepted current channel.
REQ-010 sample_en  out  1  sampling core running.
REQ-011 trigger_out  out  1  one-cycle pulse when the delay expires.
REQ-012 trig_latched  out  8  masked hit pattern captured at trigger.
REQ-013 readout_req  out  1  channel readout request.
REQ-014 readout_ch  out  3  channel index under readout.
REQ-015 core_rst  out  1  reset to sampling core.
REQ-016 busy  out  1  state != IDLE.
REQ-017 trig_count  out  8  triggers since reset, wraps 255->0.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, DELAY, HOLD, READOUT and CLEAR; all outputs SHALL be registered.
REQ-019 Same-cycle pulse priority SHALL be inst_rst > inst_readout > inst_start; lower-priority pulses are dropped.
REQ-020 inst_rst in any state SHALL enter CLEAR next cycle, drive core_rst=1 for exactly 4 cycles, clear trig_latched, trig_count and readout_req, then return to IDLE.
REQ-021 IDLE + inst_start SHALL enter ARMED with sample_en=1 from the next cycle; inst_start outside IDLE SHALL be ignored.
REQ-022 ARMED with (trig_in & trigger_channel_mask) != 0 SHALL latch that value into trig_latched, increment trig_count, load the delay counter with trig_delay and enter DELAY.
REQ-023 DELAY SHALL decrement the counter each cycle; at counter==0 it SHALL enter HOLD, drop sample_en and pulse trigger_out for one cycle.
REQ-024 If trig_delay==0, HOLD SHALL be entered one cycle after the trigger, so trigger_out is 1 cycle after the capture edge; with delay N it is N+1 cycles.
REQ-025 trig_in during DELAY, HOLD or READOUT SHALL be ignored, with no re-latch and no count.
REQ-026 HOLD + inst_readout SHALL enter READOUT.
REQ-027 ARMED + inst_readout (forced readout) SHALL set trig_latched=trigger_channel_mask, drop sample_en and enter READOUT; if the mask is 0 it SHALL go to IDLE instead.
REQ-028 inst_readout in IDLE, DELAY, READOUT or CLEAR SHALL be ignored.
REQ-029 READOUT SHALL hold readout_req=1 with readout_ch = lowest set bit of trig_latched not yet served, visiting set bits in ascending order.
REQ-030 On readout_ack while readout_req=1, readout_ch SHALL advance to the next set bit on the next cycle.
REQ-031 If no set bit remains after an ack, readout_req SHALL drop, trig_latched SHALL clear and the FSM SHALL enter IDLE next cycle.
REQ-032 readout_ack while readout_req=0 SHALL be ignored.
REQ-033 inst_rst during READOUT SHALL abandon remaining channels immediately.
REQ-034 trig_count SHALL be 8-bit modulo 256.

Reset
REQ-035 rst=1 SHALL force IDLE, sample_en=0, trigger_out=0, trig_latched=0, readout_req=0, readout_ch=0, core_rst=0, busy=0, trig_count=0, delay counter=0; this overrides all pulses in the same cycle.

Verification
REQ-036 mask=8'h05, trig_delay=3, inst_start, then trig_in=8'h07 -> trig_latched=8'h05, trig_count=1, trigger_out 4 cycles after capture, sample_en=0.
REQ-037 After REQ-036, inst_readout with ack 2 cycles after each req -> readout_ch 0 then 2, readout_req drops after the second ack, FSM in IDLE, busy=0.
REQ-038 ARMED, mask=8'h00, inst_readout -> IDLE next cycle, readout_req never asserted.
REQ-039 inst_rst and inst_start in the same cycle during READOUT -> core_rst high for exactly 4 cycles, readout_req=0, then IDLE; start ignored.
REQ-040 256 triggers each followed by readout -> trig_count wraps to 0.
REQ-041 rst=1 while in DELAY -> all outputs at reset values next edge, and no trigger_out.
